// File: rtl/row_stats_accum.sv
// row_stats_accum: pipelined per-row sum / sum-of-squares reducer feeding the LayerNorm mean/variance stage.
// Define ROW_STATS_ABORT_EN to add the i_abort port, which drops the partial row and any in-flight beats.
module row_stats_accum #(
   parameter  int DATA_W = 16,
   parameter  int LANES  = 64,
   parameter  int BEATS  = 12,
   localparam int L      = $clog2(LANES),
   localparam int B      = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int SUM_W  = DATA_W + L + B,
   localparam int SQ_W   = 2*DATA_W + L + B
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_valid,
   input  logic [DATA_W*LANES-1:0]   i_data_flat,
`ifdef ROW_STATS_ABORT_EN
   input  logic                      i_abort,
`endif
   output logic                      o_valid,
   output logic signed [SUM_W-1:0]   o_sum,
   output logic signed [SQ_W-1:0]    o_sq_sum
);

   localparam int NODES = 2*LANES - 1;
   localparam int TS_W  = DATA_W + L;
   localparam int TQ_W  = 2*DATA_W + L;
   localparam logic [B-1:0] CNT_LAST = B'(BEATS - 1);

   function automatic logic signed [2*DATA_W-1:0] square(input logic signed [DATA_W-1:0] x);
      logic signed [2*DATA_W-1:0] xe;
      xe = (2*DATA_W)'(x);
      return xe * xe;
   endfunction

   // Heap-ordered tree: node i sums children 2i+1 and 2i+2; leaves LANES-1.. hold the lanes.
   logic signed [TS_W-1:0] node_sum_d [NODES];
   logic signed [TS_W-1:0] node_sum_q [NODES];
   logic signed [TQ_W-1:0] node_sq_d  [NODES];
   logic signed [TQ_W-1:0] node_sq_q  [NODES];

   logic [L:0]              vld_d, vld_q;
   logic [B-1:0]            cnt_d, cnt_q;
   logic signed [SUM_W-1:0] acc_sum_d, acc_sum_q;
   logic signed [SQ_W-1:0]  acc_sq_d, acc_sq_q;
   logic                    o_valid_d, o_valid_q;
   logic signed [SUM_W-1:0] o_sum_d, o_sum_q;
   logic signed [SQ_W-1:0]  o_sq_sum_d, o_sq_sum_q;

   logic                    abort_s;
   logic signed [SUM_W-1:0] tree_sum_s, row_sum_s;
   logic signed [SQ_W-1:0]  tree_sq_s, row_sq_s;

`ifdef ROW_STATS_ABORT_EN
   assign abort_s = i_abort;
`else
   assign abort_s = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < LANES-1; i++) begin
         node_sum_d[i] = node_sum_q[2*i+1] + node_sum_q[2*i+2];
         node_sq_d[i]  = node_sq_q[2*i+1]  + node_sq_q[2*i+2];
      end
      for (int k = 0; k < LANES; k++) begin
         node_sum_d[LANES-1+k] = TS_W'($signed(i_data_flat[DATA_W*k +: DATA_W]));
         node_sq_d[LANES-1+k]  = TQ_W'(square(i_data_flat[DATA_W*k +: DATA_W]));
      end
   end

   // Tree data loads every cycle; only the valid shift register qualifies it.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < NODES; i++) begin
         node_sum_q[i] <= node_sum_d[i];
         node_sq_q[i]  <= node_sq_d[i];
      end
   end

   assign tree_sum_s = SUM_W'(node_sum_q[0]);
   assign tree_sq_s  = SQ_W'(node_sq_q[0]);
   assign row_sum_s  = (cnt_q == {B{1'b0}}) ? tree_sum_s : acc_sum_q + tree_sum_s;
   assign row_sq_s   = (cnt_q == {B{1'b0}}) ? tree_sq_s  : acc_sq_q  + tree_sq_s;

   always_comb begin
      vld_d      = vld_q;
      cnt_d      = cnt_q;
      acc_sum_d  = acc_sum_q;
      acc_sq_d   = acc_sq_q;
      o_valid_d  = 1'b0;
      o_sum_d    = o_sum_q;
      o_sq_sum_d = o_sq_sum_q;
      if (abort_s) begin
         vld_d     = {(L+1){1'b0}};
         cnt_d     = {B{1'b0}};
         acc_sum_d = {SUM_W{1'b0}};
         acc_sq_d  = {SQ_W{1'b0}};
      end else begin
         vld_d = {vld_q[L-1:0], i_valid};
         if (vld_q[L]) begin
            acc_sum_d = row_sum_s;
            acc_sq_d  = row_sq_s;
            if (cnt_q == CNT_LAST) begin
               o_valid_d  = 1'b1;
               o_sum_d    = row_sum_s;
               o_sq_sum_d = row_sq_s;
               cnt_d      = {B{1'b0}};
            end else begin
               cnt_d = cnt_q + B'(1);
            end
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   // Control, accumulator and output registers; reset discards any partial row.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q      <= {(L+1){1'b0}};
         cnt_q      <= {B{1'b0}};
         acc_sum_q  <= {SUM_W{1'b0}};
         acc_sq_q   <= {SQ_W{1'b0}};
         o_valid_q  <= 1'b0;
         o_sum_q    <= {SUM_W{1'b0}};
         o_sq_sum_q <= {SQ_W{1'b0}};
      end else begin
         vld_q      <= vld_d;
         cnt_q      <= cnt_d;
         acc_sum_q  <= acc_sum_d;
         acc_sq_q   <= acc_sq_d;
         o_valid_q  <= o_valid_d;
         o_sum_q    <= o_sum_d;
         o_sq_sum_q <= o_sq_sum_d;
      end
   end

   assign o_valid  = o_valid_q;
   assign o_sum    = o_sum_q;
   assign o_sq_sum = o_sq_sum_q;

endmodule

// File: tb/tb_row_stats_accum.sv
// Directed self-checking bench for row_stats_accum with DATA_W=16, LANES=64, BEATS=4.
module tb_row_stats_accum;
   localparam int DATA_W = 16;
   localparam int LANES  = 64;
   localparam int BEATS  = 4;
   localparam int SUM_W  = 24;
   localparam int SQ_W   = 40;

   logic                     i_clk = 1'b0;
   logic                     i_rst;
   logic                     i_valid;
   logic [DATA_W*LANES-1:0]  i_data_flat;
`ifdef ROW_STATS_ABORT_EN
   logic                     i_abort;
`endif
   logic                     o_valid;
   logic signed [SUM_W-1:0]  o_sum;
   logic signed [SQ_W-1:0]   o_sq_sum;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int last_cyc;
   int c_a;
   int pq_cyc[$];
   logic signed [63:0] pq_sum[$];
   logic signed [63:0] pq_sq[$];

   row_stats_accum #(.DATA_W(DATA_W), .LANES(LANES), .BEATS(BEATS)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .i_data_flat (i_data_flat),
`ifdef ROW_STATS_ABORT_EN
      .i_abort     (i_abort),
`endif
      .o_valid     (o_valid),
      .o_sum       (o_sum),
      .o_sq_sum    (o_sq_sum)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Record every output pulse with the number of rising edges seen so far.
   always @(negedge i_clk) begin
      if (o_valid === 1'b1) begin
         pq_cyc.push_back(cyc);
         pq_sum.push_back(64'($signed(o_sum)));
         pq_sq.push_back(64'($signed(o_sq_sum)));
      end
   end

   task automatic clear_q();
      pq_cyc.delete();
      pq_sum.delete();
      pq_sq.delete();
   endtask

   task automatic pad_q(input int n);
      while (pq_cyc.size() < n) begin
         pq_cyc.push_back(-1);
         pq_sum.push_back('x);
         pq_sq.push_back('x);
      end
   endtask

   task automatic drive_all(input logic signed [DATA_W-1:0] v);
      @(negedge i_clk);
      i_rst   = 1'b0;
`ifdef ROW_STATS_ABORT_EN
      i_abort = 1'b0;
`endif
      i_valid = 1'b1;
      for (int k = 0; k < LANES; k++) i_data_flat[DATA_W*k +: DATA_W] = v;
      last_cyc = cyc;
   endtask

   task automatic drive_index();
      @(negedge i_clk);
      i_valid = 1'b1;
      for (int k = 0; k < LANES; k++) i_data_flat[DATA_W*k +: DATA_W] = DATA_W'(k);
      last_cyc = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         i_rst   = 1'b0;
         i_valid = 1'b0;
`ifdef ROW_STATS_ABORT_EN
         i_abort = 1'b0;
`endif
      end
      #1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_valid = 1'b0;
      i_data_flat = '0;
`ifdef ROW_STATS_ABORT_EN
      i_abort = 1'b0;
`endif
      clear_q();
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      idle(2);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      checks++; if (o_sum !== 24'sd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", o_sum); end
      checks++; if (o_sq_sum !== 40'sd0) begin errors++; $display("FAIL reset_sq: got %0d expected 0", o_sq_sum); end
      checks++; if (pq_cyc.size() !== 0) begin errors++; $display("FAIL reset_pulses: got %0d expected 0", pq_cyc.size()); end
   endtask

   task automatic test_all_ones();
      clear_q();
      for (int b = 0; b < BEATS; b++) drive_all(16'sd1);
      idle(12);
      checks++; if (pq_cyc.size() !== 1) begin errors++; $display("FAIL ones_count: got %0d expected 1", pq_cyc.size()); end
      pad_q(1);
      checks++; if (pq_cyc[0] !== last_cyc + 8) begin errors++; $display("FAIL ones_latency: got %0d expected %0d", pq_cyc[0], last_cyc + 8); end
      checks++; if (pq_sum[0] !== 64'sd256) begin errors++; $display("FAIL ones_sum: got %0d expected 256", pq_sum[0]); end
      checks++; if (pq_sq[0] !== 64'sd256) begin errors++; $display("FAIL ones_sq: got %0d expected 256", pq_sq[0]); end
   endtask

   task automatic test_extreme_neg();
      clear_q();
      for (int b = 0; b < BEATS; b++) drive_all(-16'sd32768);
      idle(12);
      checks++; if (pq_cyc.size() !== 1) begin errors++; $display("FAIL neg_count: got %0d expected 1", pq_cyc.size()); end
      pad_q(1);
      checks++; if (pq_cyc[0] !== last_cyc + 8) begin errors++; $display("FAIL neg_latency: got %0d expected %0d", pq_cyc[0], last_cyc + 8); end
      checks++; if (pq_sum[0] !== -64'sd8388608) begin errors++; $display("FAIL neg_sum: got %0d expected -8388608", pq_sum[0]); end
      checks++; if (pq_sq[0] !== 64'sd274877906944) begin errors++; $display("FAIL neg_sq: got %0d expected 274877906944", pq_sq[0]); end
   endtask

   task automatic test_bubbles();
      clear_q();
      drive_index(); idle(1);
      drive_index(); idle(2);
      drive_index(); idle(3);
      drive_index();
      idle(12);
      checks++; if (pq_cyc.size() !== 1) begin errors++; $display("FAIL bubble_count: got %0d expected 1", pq_cyc.size()); end
      pad_q(1);
      checks++; if (pq_cyc[0] !== last_cyc + 8) begin errors++; $display("FAIL bubble_latency: got %0d expected %0d", pq_cyc[0], last_cyc + 8); end
      checks++; if (pq_sum[0] !== 64'sd8064) begin errors++; $display("FAIL bubble_sum: got %0d expected 8064", pq_sum[0]); end
      checks++; if (pq_sq[0] !== 64'sd341376) begin errors++; $display("FAIL bubble_sq: got %0d expected 341376", pq_sq[0]); end
   endtask

   task automatic test_back_to_back();
      clear_q();
      for (int b = 0; b < BEATS; b++) drive_all(16'sd1);
      c_a = last_cyc;
      for (int b = 0; b < BEATS; b++) drive_all(16'sd2);
      idle(16);
      checks++; if (pq_cyc.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", pq_cyc.size()); end
      pad_q(2);
      checks++; if (pq_cyc[0] !== c_a + 8) begin errors++; $display("FAIL b2b_first_time: got %0d expected %0d", pq_cyc[0], c_a + 8); end
      checks++; if (pq_cyc[1] !== c_a + 12) begin errors++; $display("FAIL b2b_second_time: got %0d expected %0d", pq_cyc[1], c_a + 12); end
      checks++; if (pq_sum[0] !== 64'sd256) begin errors++; $display("FAIL b2b_sum_a: got %0d expected 256", pq_sum[0]); end
      checks++; if (pq_sq[0] !== 64'sd256) begin errors++; $display("FAIL b2b_sq_a: got %0d expected 256", pq_sq[0]); end
      checks++; if (pq_sum[1] !== 64'sd512) begin errors++; $display("FAIL b2b_sum_b: got %0d expected 512", pq_sum[1]); end
      checks++; if (pq_sq[1] !== 64'sd1024) begin errors++; $display("FAIL b2b_sq_b: got %0d expected 1024", pq_sq[1]); end
      checks++; if (o_sum !== 24'sd512) begin errors++; $display("FAIL b2b_hold_sum: got %0d expected 512", o_sum); end
      checks++; if (o_sq_sum !== 40'sd1024) begin errors++; $display("FAIL b2b_hold_sq: got %0d expected 1024", o_sq_sum); end
   endtask

`ifdef ROW_STATS_ABORT_EN
   task automatic test_abort();
      clear_q();
      for (int b = 0; b < 3; b++) drive_all(16'sd5);
      drive_all(16'sd5);
      i_abort = 1'b1;
      for (int b = 0; b < BEATS; b++) drive_all(16'sd1);
      checks++; if (o_sum !== 24'sd512) begin errors++; $display("FAIL abort_hold_sum: got %0d expected 512", o_sum); end
      checks++; if (o_sq_sum !== 40'sd1024) begin errors++; $display("FAIL abort_hold_sq: got %0d expected 1024", o_sq_sum); end
      idle(12);
      checks++; if (pq_cyc.size() !== 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", pq_cyc.size()); end
      pad_q(1);
      checks++; if (pq_cyc[0] !== last_cyc + 8) begin errors++; $display("FAIL abort_latency: got %0d expected %0d", pq_cyc[0], last_cyc + 8); end
      checks++; if (pq_sum[0] !== 64'sd256) begin errors++; $display("FAIL abort_sum: got %0d expected 256", pq_sum[0]); end
      checks++; if (pq_sq[0] !== 64'sd256) begin errors++; $display("FAIL abort_sq: got %0d expected 256", pq_sq[0]); end
   endtask
`endif

   task automatic test_reset_mid_row();
      clear_q();
      drive_all(16'sd7);
      drive_all(16'sd7);
      drive_all(16'sd7);
      i_rst = 1'b1;
      drive_all(16'sd1);
      checks++; if (o_sum !== 24'sd0) begin errors++; $display("FAIL rst_mid_sum_cleared: got %0d expected 0", o_sum); end
      checks++; if (o_sq_sum !== 40'sd0) begin errors++; $display("FAIL rst_mid_sq_cleared: got %0d expected 0", o_sq_sum); end
      for (int b = 1; b < BEATS; b++) drive_all(16'sd1);
      idle(12);
      checks++; if (pq_cyc.size() !== 1) begin errors++; $display("FAIL rst_mid_count: got %0d expected 1", pq_cyc.size()); end
      pad_q(1);
      checks++; if (pq_cyc[0] !== last_cyc + 8) begin errors++; $display("FAIL rst_mid_latency: got %0d expected %0d", pq_cyc[0], last_cyc + 8); end
      checks++; if (pq_sum[0] !== 64'sd256) begin errors++; $display("FAIL rst_mid_sum: got %0d expected 256", pq_sum[0]); end
      checks++; if (pq_sq[0] !== 64'sd256) begin errors++; $display("FAIL rst_mid_sq: got %0d expected 256", pq_sq[0]); end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_extreme_neg();
      test_bubbles();
      test_back_to_back();
`ifdef ROW_STATS_ABORT_EN
      test_abort();
`endif
      test_reset_mid_row();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
